instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Producer side of the IFU→IDU instruction interface; drives `ifu2idu_inst` into the instruction decode unit.
- Holds the PC and issues one outstanding fetch to instruction memory over a valid/ready request plus valid-only response channel.
- Presents the fetched word to the IDU with a valid/ready handshake.
- Accepts a redirect (branch/jump target) from the execute stage; any in-flight fetch for the old PC is squashed.

Parameters:
- INST_WIDTH, 32, instruction word width.
- PC_WIDTH, 64, PC and fetch address width.
- RESET_PC, 64'h8000_0000, first fetch address after reset.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  PC_WIDTH  fetch address, word-aligned.
- imem_rsp_valid  in  1  response valid; no back-pressure.
- imem_rsp_data  in  INST_WIDTH  fetched word.
- imem_rsp_err  in  1  access fault for this response.
- ifu2idu_valid  out  1  instruction valid to IDU.
- ifu2idu_ready  in  1  IDU consumes instruction.
- ifu2idu_inst  out  INST_WIDTH  instruction word.
- ifu2idu_pc  out  PC_WIDTH  PC of `ifu2idu_inst`.
- ifu2idu_err  out  1  fetch fault or misaligned redirect.
- redirect_valid  in  1  next-PC override.
- redirect_pc  in  PC_WIDTH  redirect target.

Behaviour:
- **Reset** (rst_n=0 at an edge):
  - state=S_IDLE, pc=RESET_PC, drop=0.
  - inst reg=0, err reg=0.
  - Outputs: imem_req_valid=0, ifu2idu_valid=0, ifu2idu_inst=0, ifu2idu_err=0, ifu2idu_pc=RESET_PC.
  - Reset mid-transaction abandons all state. A response arriving after reset release with no request outstanding is ignored.
- **States:** S_IDLE, S_REQ, S_WAIT, S_OUT.
- **S_IDLE:** next state is S_REQ unconditionally, so the first request goes out one cycle after reset release.
- **S_REQ:**
  - imem_req_valid=1, imem_req_addr={pc[PC_WIDTH-1:2],2'b00}.
  - On accept (valid&ready) → S_WAIT.
  - The address may change while not accepted only due to a redirect.
- **S_WAIT:**
  - Earliest response is the cycle after acceptance.
  - On imem_rsp_valid with drop=0: latch data, latch err (imem_rsp_err | pc[1:0]!=0), then → S_OUT.
  - On imem_rsp_valid with drop=1: discard the response, clear drop, → S_REQ.
- **S_OUT:**
  - ifu2idu_valid=1; inst, pc and err are stable until the handshake.
  - On handshake without redirect: pc ← pc+4 (mod 2^PC_WIDTH, wraps), → S_REQ.
- **Redirect (any state except S_IDLE):** pc ← redirect_pc.
  - S_REQ, request not accepted the same cycle: stay S_REQ; the new address appears next cycle.
  - S_REQ, request accepted the same cycle: → S_WAIT with drop=1.
  - S_WAIT: drop ← 1 and pc ← redirect_pc. If a response arrives the same cycle, it is discarded and the next state is S_REQ.
  - S_OUT: ifu2idu_valid deasserts next cycle, → S_REQ. If ifu2idu_ready is high in the same cycle, the transfer still completes (IDU owns that instruction), and pc takes redirect_pc, not pc+4.
  - Redirect while drop is already 1: only pc updates.
- **Throughput:** at most one instruction per 3 cycles (REQ→WAIT→OUT with zero-wait memory and ready IDU). Only one fetch is ever outstanding.
- **Misaligned PC:** the address is forced aligned and the instruction is delivered with ifu2idu_err=1. The IDU/exception logic handles it; the IFU does not stall.

Decomposition:
- Shared package `npc_ifu_pkg`:
  - state enum (S_IDLE=2'd0, S_REQ=2'd1, S_WAIT=2'd2, S_OUT=2'd3);
  - RESET_PC default;
  - INST_WIDTH/PC_WIDTH defaults;
  - PC increment constant 4.
- One sub-module, `ifu_pc_reg`: PC register with the reset/redirect/increment priority mux (redirect > handshake increment > hold). The FSM and output buffer stay in the top module.

Test Plan:
1. Release reset, mem ready=1, rsp one cycle after accept with data 32'h00000413 → req addr 8000_0000 in cycle 2; ifu2idu_valid with inst 00000413 and pc 8000_0000 in cycle 4; next req addr 8000_0004.
2. Hold ifu2idu_ready=0 for 5 cycles in S_OUT → valid, inst and pc held constant, no new request; on ready=1 the next cycle requests pc+4.
3. Redirect to 8000_0100 while in S_WAIT; the old response arrives 3 cycles later with 32'hDEADBEEF → word never shown to IDU; next req addr 8000_0100.
4. Redirect to 8000_0200 in the same cycle as the S_OUT handshake → IDU receives the current instruction once; next req addr 8000_0200, not pc+4.
5. Redirect to 8000_0102 → req addr 8000_0100; delivered instruction has ifu2idu_err=1 and ifu2idu_pc=8000_0102. Separately, imem_rsp_err=1 → ifu2idu_err=1.
6. Assert rst_n=0 during S_WAIT, then release; the stale response arrives → ignored; first request after release is RESET_PC, and all outputs are at reset values during reset.

Source files
------------

// File: rtl/npc_ifu_pkg.sv
// Shared types and defaults for the instruction fetch unit: FSM state
// encoding, datapath widths, reset vector and sequential PC stride.
package npc_ifu_pkg;

  localparam int unsigned IFU_INST_WIDTH = 32;
  localparam int unsigned IFU_PC_WIDTH   = 64;
  localparam logic [63:0] IFU_RESET_PC   = 64'h8000_0000;
  localparam int unsigned PC_INCR        = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } ifu_state_e;

  // Fetch address is always word aligned; the low bits only feed the fault flag.
  function automatic logic [IFU_PC_WIDTH-1:0] align_word(input logic [IFU_PC_WIDTH-1:0] pc);
    return {pc[IFU_PC_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_pc_reg.sv
// Program counter register: a redirect wins over the sequential increment,
// which wins over hold. Reset loads the reset vector.
module ifu_pc_reg
  import npc_ifu_pkg::*;
#(
  parameter int unsigned          PC_WIDTH = IFU_PC_WIDTH,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = IFU_RESET_PC[PC_WIDTH-1:0]
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                redirect_en,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  input  logic                incr_en,
  output logic [PC_WIDTH-1:0] pc_o
);

  logic [PC_WIDTH-1:0] pc_d;
  logic [PC_WIDTH-1:0] pc_q;

  always_comb begin
    pc_d = pc_q;
    if (redirect_en) begin
      pc_d = redirect_pc;
    end else if (incr_en) begin
      pc_d = pc_q + PC_WIDTH'(PC_INCR);
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Single-outstanding instruction fetcher: requests the word at the PC, buffers
// the response and hands it to the decode stage, squashing fetches on redirect.
module instruction_fetch_unit
  import npc_ifu_pkg::*;
#(
  parameter int unsigned          INST_WIDTH = IFU_INST_WIDTH,
  parameter int unsigned          PC_WIDTH   = IFU_PC_WIDTH,
  parameter logic [PC_WIDTH-1:0]  RESET_PC   = IFU_RESET_PC[PC_WIDTH-1:0]
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [PC_WIDTH-1:0]   imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [INST_WIDTH-1:0] imem_rsp_data,
  input  logic                  imem_rsp_err,
  output logic                  ifu2idu_valid,
  input  logic                  ifu2idu_ready,
  output logic [INST_WIDTH-1:0] ifu2idu_inst,
  output logic [PC_WIDTH-1:0]   ifu2idu_pc,
  output logic                  ifu2idu_err,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc
);

  ifu_state_e            state_d, state_q;
  logic                  drop_d, drop_q;
  logic [INST_WIDTH-1:0] inst_d, inst_q;
  logic                  err_d, err_q;
  logic                  req_valid_d, req_valid_q;
  logic                  out_valid_d, out_valid_q;

  logic [PC_WIDTH-1:0]   pc;
  logic                  redirect_en;
  logic                  req_fire;
  logic                  out_fire;

  assign redirect_en = redirect_valid && (state_q != S_IDLE);
  assign req_fire    = req_valid_q && imem_req_ready;
  assign out_fire    = out_valid_q && ifu2idu_ready;

  ifu_pc_reg #(
    .PC_WIDTH (PC_WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .incr_en     (out_fire),
    .pc_o        (pc)
  );

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    inst_d  = inst_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: state_d = S_REQ;

      S_REQ: begin
        if (req_fire) begin
          state_d = S_WAIT;
          // The accepted request targets the old PC; its response must be squashed.
          if (redirect_en) drop_d = 1'b1;
        end
      end

      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (redirect_en || drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            inst_d  = imem_rsp_data;
            err_d   = imem_rsp_err || (pc[1:0] != 2'b00);
            state_d = S_OUT;
          end
        end else if (redirect_en) begin
          drop_d = 1'b1;
        end
      end

      S_OUT: begin
        if (out_fire || redirect_en) state_d = S_REQ;
      end
    endcase

    req_valid_d = (state_d == S_REQ);
    out_valid_d = (state_d == S_OUT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      drop_q      <= 1'b0;
      inst_q      <= '0;
      err_q       <= 1'b0;
      req_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drop_q      <= drop_d;
      inst_q      <= inst_d;
      err_q       <= err_d;
      req_valid_q <= req_valid_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = align_word(pc);
  assign ifu2idu_valid  = out_valid_q;
  assign ifu2idu_inst   = inst_q;
  assign ifu2idu_pc     = pc;
  assign ifu2idu_err    = err_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: reset, basic fetch, IDU stall,
// redirect squashing, misalignment/fault flags, wrap and reset mid-fetch.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        ifu2idu_valid;
  logic        ifu2idu_ready;
  logic [31:0] ifu2idu_inst;
  logic [63:0] ifu2idu_pc;
  logic        ifu2idu_err;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  int errors = 0;
  int checks = 0;

  instruction_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .ifu2idu_valid  (ifu2idu_valid),
    .ifu2idu_ready  (ifu2idu_ready),
    .ifu2idu_inst   (ifu2idu_inst),
    .ifu2idu_pc     (ifu2idu_pc),
    .ifu2idu_err    (ifu2idu_err),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_rsp_err   = 1'b0;
    ifu2idu_ready  = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
  endtask

  // Reset, release, and advance to the first S_REQ cycle.
  task automatic start();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid); end
    checks++; if (ifu2idu_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", ifu2idu_valid); end
    checks++; if (ifu2idu_inst !== 32'h0) begin errors++; $display("FAIL reset_inst got=%h exp=0", ifu2idu_inst); end
    checks++; if (ifu2idu_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", ifu2idu_err); end
    checks++; if (ifu2idu_pc !== 64'h8000_0000) begin errors++; $display("FAIL reset_pc got=%h exp=80000000", ifu2idu_pc); end
    rst_n = 1'b1;
    step();  // cycle 1 after release: S_IDLE
  endtask

  task automatic test_basic_fetch();
    start();
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0000) begin errors++; $display("FAIL basic_req got=%b/%h exp=1/80000000", imem_req_valid, imem_req_addr); end
    step();  // accepted -> S_WAIT
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL basic_wait_req got=%b exp=0", imem_req_valid); end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_0413;
    step();
    imem_rsp_valid = 1'b0;
    checks++; if (ifu2idu_valid !== 1'b1 || ifu2idu_inst !== 32'h0000_0413) begin errors++; $display("FAIL basic_out got=%b/%h exp=1/00000413", ifu2idu_valid, ifu2idu_inst); end
    checks++; if (ifu2idu_pc !== 64'h8000_0000 || ifu2idu_err !== 1'b0) begin errors++; $display("FAIL basic_pc_err got=%h/%b exp=80000000/0", ifu2idu_pc, ifu2idu_err); end
    step();  // handshake -> S_REQ at pc+4
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0004) begin errors++; $display("FAIL basic_next_req got=%b/%h exp=1/80000004", imem_req_valid, imem_req_addr); end
    checks++; if (ifu2idu_valid !== 1'b0) begin errors++; $display("FAIL basic_out_drop got=%b exp=0", ifu2idu_valid); end
  endtask

  task automatic test_idu_stall();
    start();
    step();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h1234_5678;
    ifu2idu_ready  = 1'b0;
    step();
    imem_rsp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ifu2idu_valid !== 1'b1 || ifu2idu_inst !== 32'h1234_5678 || ifu2idu_pc !== 64'h8000_0000 || imem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d] got=%b/%h/%h/req%b exp=1/12345678/80000000/req0", i, ifu2idu_valid, ifu2idu_inst, ifu2idu_pc, imem_req_valid);
      end
      step();
    end
    checks++; if (ifu2idu_valid !== 1'b1) begin errors++; $display("FAIL stall_still_valid got=%b exp=1", ifu2idu_valid); end
    ifu2idu_ready = 1'b1;
    step();
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0004) begin errors++; $display("FAIL stall_next_req got=%b/%h exp=1/80000004", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_redirect_wait();
    start();
    step();  // S_WAIT
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0100;
    step();
    redirect_valid = 1'b0;
    step();
    step();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    checks++; if (ifu2idu_valid !== 1'b0 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL rdw_waiting got=%b/%b exp=0/0", ifu2idu_valid, imem_req_valid); end
    step();
    imem_rsp_valid = 1'b0;
    checks++; if (ifu2idu_valid !== 1'b0) begin errors++; $display("FAIL rdw_stale_shown got=%b exp=0", ifu2idu_valid); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0100) begin errors++; $display("FAIL rdw_new_req got=%b/%h exp=1/80000100", imem_req_valid, imem_req_addr); end
    step();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_0013;
    step();
    imem_rsp_valid = 1'b0;
    checks++; if (ifu2idu_valid !== 1'b1 || ifu2idu_inst !== 32'h0000_0013 || ifu2idu_pc !== 64'h8000_0100) begin errors++; $display("FAIL rdw_refetch got=%b/%h/%h exp=1/00000013/80000100", ifu2idu_valid, ifu2idu_inst, ifu2idu_pc); end
  endtask

  task automatic test_redirect_req_accept();
    start();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0300;
    step();  // accepted with redirect -> S_WAIT, drop
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_0777;
    step();
    imem_rsp_valid = 1'b0;
    checks++; if (ifu2idu_valid !== 1'b0) begin errors++; $display("FAIL rra_stale_shown got=%b exp=0", ifu2idu_valid); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0300) begin errors++; $display("FAIL rra_new_req got=%b/%h exp=1/80000300", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_redirect_handshake();
    start();
    step();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_00AA;
    step();
    imem_rsp_valid = 1'b0;
    checks++; if (ifu2idu_valid !== 1'b1 || ifu2idu_inst !== 32'h0000_00AA) begin errors++; $display("FAIL rhs_out got=%b/%h exp=1/000000aa", ifu2idu_valid, ifu2idu_inst); end
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0200;
    step();
    redirect_valid = 1'b0;
    checks++; if (ifu2idu_valid !== 1'b0) begin errors++; $display("FAIL rhs_single_xfer got=%b exp=0", ifu2idu_valid); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0200) begin errors++; $display("FAIL rhs_next_req got=%b/%h exp=1/80000200", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_misaligned_and_fault();
    start();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0102;
    step();
    redirect_valid = 1'b0;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0100) begin errors++; $display("FAIL mis_req got=%b/%h exp=1/80000100", imem_req_valid, imem_req_addr); end
    imem_req_ready = 1'b1;
    step();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_0033;
    step();
    imem_rsp_valid = 1'b0;
    checks++; if (ifu2idu_valid !== 1'b1 || ifu2idu_err !== 1'b1 || ifu2idu_pc !== 64'h8000_0102) begin errors++; $display("FAIL mis_out got=%b/%b/%h exp=1/1/80000102", ifu2idu_valid, ifu2idu_err, ifu2idu_pc); end
    step();
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0104) begin errors++; $display("FAIL mis_next_req got=%b/%h exp=1/80000104", imem_req_valid, imem_req_addr); end

    start();
    step();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_0044;
    imem_rsp_err   = 1'b1;
    step();
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
    checks++; if (ifu2idu_valid !== 1'b1 || ifu2idu_err !== 1'b1 || ifu2idu_inst !== 32'h0000_0044) begin errors++; $display("FAIL fault_out got=%b/%b/%h exp=1/1/00000044", ifu2idu_valid, ifu2idu_err, ifu2idu_inst); end
  endtask

  task automatic test_pc_wrap();
    start();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    step();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_0099;
    step();
    imem_rsp_valid = 1'b0;
    checks++; if (ifu2idu_pc !== 64'hFFFF_FFFF_FFFF_FFFC || ifu2idu_err !== 1'b0) begin errors++; $display("FAIL wrap_out got=%h/%b exp=fffffffffffffffc/0", ifu2idu_pc, ifu2idu_err); end
    step();
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0) begin errors++; $display("FAIL wrap_next_req got=%b/%h exp=1/0", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_reset_mid_wait();
    start();
    step();  // S_WAIT
    rst_n = 1'b0;
    step();
    checks++; if (imem_req_valid !== 1'b0 || ifu2idu_valid !== 1'b0 || ifu2idu_pc !== 64'h8000_0000) begin errors++; $display("FAIL rmw_in_reset got=%b/%b/%h exp=0/0/80000000", imem_req_valid, ifu2idu_valid, ifu2idu_pc); end
    step();
    rst_n          = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    step();  // S_IDLE -> S_REQ, stale response ignored
    imem_rsp_valid = 1'b0;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0000 || ifu2idu_valid !== 1'b0) begin errors++; $display("FAIL rmw_first_req got=%b/%h/%b exp=1/80000000/0", imem_req_valid, imem_req_addr, ifu2idu_valid); end
    imem_req_ready = 1'b1;
    step();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_0055;
    step();
    imem_rsp_valid = 1'b0;
    checks++; if (ifu2idu_valid !== 1'b1 || ifu2idu_inst !== 32'h0000_0055 || ifu2idu_pc !== 64'h8000_0000) begin errors++; $display("FAIL rmw_fetch got=%b/%h/%h exp=1/00000055/80000000", ifu2idu_valid, ifu2idu_inst, ifu2idu_pc); end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_basic_fetch();
    test_idu_stall();
    test_redirect_wait();
    test_redirect_req_accept();
    test_redirect_handshake();
    test_misaligned_and_fault();
    test_pc_wrap();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
